// File: rtl/uart_rx_host_ctrl.sv
// UART receive-side host controller: buffers received bytes in a small circular
// FIFO, tracks sticky error flags, and hands bytes to the host via interrupt/ack.
module uart_rx_host_ctrl #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                          overSampler,
   input  logic                          reset,
   input  logic [7:0]                    rxData,
   input  logic                          rxValid,
   input  logic                          rxParityErr,
   input  logic                          rxFrameErr,
   output logic [7:0]                    hostData,
   output logic                          hostInterrupt,
   input  logic                          hostAck,
   output logic [2:0]                    errStatus,
   input  logic                          errClear,
   output logic [$clog2(FIFO_DEPTH):0]   fifoCount
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      INTR     = 2'd1,
      POP      = 2'd2,
      WAIT_REL = 2'd3
   } state_t;

   state_t          r_state;
   logic [7:0]      r_mem [FIFO_DEPTH];
   logic [AW-1:0]   r_wr_ptr;
   logic [AW-1:0]   r_rd_ptr;
   logic [CW-1:0]   r_count;
   logic            r_ack_d;
   logic            r_intr;
   logic [2:0]      r_err;

   logic            w_full;
   logic            w_empty;
   logic            w_pop;
   logic            w_push;
   logic            w_overrun;
   logic            w_ack_rise;
   logic [2:0]      w_err_set;

   assign w_full     = (r_count == CW'(FIFO_DEPTH));
   assign w_empty    = (r_count == '0);
   // The empty guard is belt-and-braces: POP is only reachable with data queued.
   assign w_pop      = (r_state == POP) && !w_empty;
   // A pop in the same cycle frees a slot, so a full FIFO still accepts the byte.
   assign w_push     = rxValid && (!w_full || w_pop);
   assign w_overrun  = rxValid && w_full && !w_pop;
   assign w_ack_rise = hostAck && !r_ack_d;
   assign w_err_set  = {rxValid && rxParityErr, rxValid && rxFrameErr, w_overrun};

   assign hostData      = r_mem[r_rd_ptr];
   assign hostInterrupt = r_intr;
   assign errStatus     = r_err;
   assign fifoCount     = r_count;

   always_ff @(posedge overSampler) begin
      if (w_push) begin
         r_mem[r_wr_ptr] <= rxData;
      end
   end

   always_ff @(posedge overSampler) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         if (w_push) begin
            r_wr_ptr <= r_wr_ptr + AW'(1);
         end
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + AW'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + CW'(1);
            2'b01:   r_count <= r_count - CW'(1);
            default: r_count <= r_count;
         endcase
      end
   end

   // Set wins over clear so an error arriving with errClear is not lost.
   always_ff @(posedge overSampler) begin
      if (reset) begin
         r_err <= 3'b000;
      end else begin
         r_err <= (errClear ? 3'b000 : r_err) | w_err_set;
      end
   end

   always_ff @(posedge overSampler) begin
      if (reset) begin
         r_ack_d <= 1'b0;
      end else begin
         r_ack_d <= hostAck;
      end
   end

   always_ff @(posedge overSampler) begin
      if (reset) begin
         r_state <= IDLE;
         r_intr  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (!w_empty) begin
                  r_state <= INTR;
                  r_intr  <= 1'b1;
               end
            end
            INTR: begin
               if (w_ack_rise) begin
                  r_state <= POP;
                  r_intr  <= 1'b0;
               end
            end
            POP: begin
               r_state <= WAIT_REL;
               r_intr  <= 1'b0;
            end
            WAIT_REL: begin
               if (!hostAck) begin
                  r_state <= IDLE;
               end
               r_intr <= 1'b0;
            end
            default: begin
               r_state <= IDLE;
               r_intr  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_rx_host_ctrl.sv
// Directed bench for uart_rx_host_ctrl: a per-cycle vector table plus
// hand-written sequences for overrun, full/pop collision, held ack and reset.
module tb_uart_rx_host_ctrl;

   logic       clk = 1'b0;
   logic       rst = 1'b0;
   logic [7:0] rxData = 8'h00;
   logic       rxValid = 1'b0;
   logic       rxParityErr = 1'b0;
   logic       rxFrameErr = 1'b0;
   logic [7:0] hostData;
   logic       hostInterrupt;
   logic       hostAck = 1'b0;
   logic [2:0] errStatus;
   logic       errClear = 1'b0;
   logic [2:0] fifoCount;

   int n_vec = 0;
   int n_err = 0;

   uart_rx_host_ctrl #(.FIFO_DEPTH(4)) dut (
      .overSampler   (clk),
      .reset         (rst),
      .rxData        (rxData),
      .rxValid       (rxValid),
      .rxParityErr   (rxParityErr),
      .rxFrameErr    (rxFrameErr),
      .hostData      (hostData),
      .hostInterrupt (hostInterrupt),
      .hostAck       (hostAck),
      .errStatus     (errStatus),
      .errClear      (errClear),
      .fifoCount     (fifoCount)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       rv;
      logic [7:0] d;
      logic       pe;
      logic       fe;
      logic       ack;
      logic       clr;
      logic       e_intr;
      logic [2:0] e_cnt;
      logic [2:0] e_err;
      logic       chk_d;
      logic [7:0] e_d;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic r, input logic rv, input logic [7:0] d, input logic pe,
                      input logic fe, input logic ack, input logic clr, input logic e_intr,
                      input logic [2:0] e_cnt, input logic [2:0] e_err, input logic chk_d,
                      input logic [7:0] e_d);
      vec_t v;
      v = '{r, rv, d, pe, fe, ack, clr, e_intr, e_cnt, e_err, chk_d, e_d};
      vecs.push_back(v);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic push(input logic [7:0] d, input logic pe, input logic fe);
      rxValid = 1'b1; rxData = d; rxParityErr = pe; rxFrameErr = fe;
      tick();
      rxValid = 1'b0; rxParityErr = 1'b0; rxFrameErr = 1'b0;
   endtask

   task automatic wait_intr();
      int t;
      t = 0;
      while (!hostInterrupt && t < 20) begin
         tick();
         t++;
      end
   endtask

   // One full acknowledge handshake, checking the presented byte first.
   task automatic hs(input logic [7:0] exp);
      wait_intr();
      chk("hs_intr", {31'd0, hostInterrupt}, 32'd1);
      chk("hs_data", {24'd0, hostData}, {24'd0, exp});
      hostAck = 1'b1;
      tick();
      chk("hs_intr_drop", {31'd0, hostInterrupt}, 32'd0);
      tick();
      hostAck = 1'b0;
      tick();
   endtask

   initial begin
      //   rst rv d      pe fe ack clr | intr cnt err     chk data
      add(1, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 1, 8'hA5, 0, 0, 0, 0,     0, 3'd1, 3'b000, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     1, 3'd1, 3'b000, 1, 8'hA5);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd1, 3'b000, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 1, 8'h3C, 1, 0, 0, 0,     0, 3'd1, 3'b100, 0, 8'h00);
      add(0, 1, 8'h7E, 0, 1, 0, 0,     1, 3'd2, 3'b110, 1, 8'h3C);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd2, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd1, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd1, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     1, 3'd1, 3'b110, 1, 8'h7E);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd1, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd0, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b110, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 1,     0, 3'd0, 3'b000, 0, 8'h00);
      add(0, 1, 8'h11, 1, 0, 0, 1,     0, 3'd1, 3'b100, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     1, 3'd1, 3'b100, 1, 8'h11);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd1, 3'b100, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 1, 0,     0, 3'd0, 3'b100, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 0,     0, 3'd0, 3'b100, 0, 8'h00);
      add(0, 0, 8'h00, 0, 0, 0, 1,     0, 3'd0, 3'b000, 0, 8'h00);

      #1;
      foreach (vecs[i]) begin
         rst = vecs[i].rst; rxValid = vecs[i].rv; rxData = vecs[i].d;
         rxParityErr = vecs[i].pe; rxFrameErr = vecs[i].fe;
         hostAck = vecs[i].ack; errClear = vecs[i].clr;
         tick();
         chk($sformatf("v%0d_intr", i), {31'd0, hostInterrupt}, {31'd0, vecs[i].e_intr});
         chk($sformatf("v%0d_cnt", i), {29'd0, fifoCount}, {29'd0, vecs[i].e_cnt});
         chk($sformatf("v%0d_err", i), {29'd0, errStatus}, {29'd0, vecs[i].e_err});
         if (vecs[i].chk_d)
            chk($sformatf("v%0d_data", i), {24'd0, hostData}, {24'd0, vecs[i].e_d});
      end
      rst = 0; rxValid = 0; rxParityErr = 0; rxFrameErr = 0; hostAck = 0; errClear = 0;

      // Burst of five into a depth-4 FIFO: fifth byte overruns and is lost.
      for (int i = 1; i <= 5; i++) push(8'(i), 1'b0, 1'b0);
      chk("burst_cnt", {29'd0, fifoCount}, 32'd4);
      chk("burst_err", {29'd0, errStatus}, 32'd1);
      chk("burst_intr", {31'd0, hostInterrupt}, 32'd1);
      for (int i = 1; i <= 4; i++) hs(8'(i));
      chk("burst_drain", {29'd0, fifoCount}, 32'd0);
      errClear = 1'b1; tick(); errClear = 1'b0;
      chk("burst_clr", {29'd0, errStatus}, 32'd0);

      // Full FIFO in POP while a new byte arrives: push and pop both land.
      for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i), 1'b0, 1'b0);
      wait_intr();
      chk("coll_head", {24'd0, hostData}, 32'hA1);
      hostAck = 1'b1; tick();
      chk("coll_full", {29'd0, fifoCount}, 32'd4);
      push(8'h99, 1'b0, 1'b0);
      chk("coll_cnt", {29'd0, fifoCount}, 32'd4);
      chk("coll_noovr", {29'd0, errStatus}, 32'd0);
      hostAck = 1'b0; tick();
      hs(8'hA2); hs(8'hA3); hs(8'hA4); hs(8'h99);
      chk("coll_drain", {29'd0, fifoCount}, 32'd0);

      // Ack held high for 20 cycles pops exactly once.
      push(8'hB1, 1'b0, 1'b0);
      push(8'hB2, 1'b0, 1'b0);
      wait_intr();
      hostAck = 1'b1;
      repeat (20) tick();
      chk("held_cnt", {29'd0, fifoCount}, 32'd1);
      chk("held_intr", {31'd0, hostInterrupt}, 32'd0);
      hostAck = 1'b0; tick();
      chk("held_rel1", {31'd0, hostInterrupt}, 32'd0);
      tick();
      chk("held_rel2", {31'd0, hostInterrupt}, 32'd1);
      chk("held_data", {24'd0, hostData}, 32'hB2);
      hs(8'hB2);

      // Reset while in INTR with three queued bytes discards everything.
      push(8'hC1, 1'b1, 1'b0);
      push(8'hC2, 1'b0, 1'b0);
      push(8'hC3, 1'b0, 1'b0);
      chk("rst_pre_intr", {31'd0, hostInterrupt}, 32'd1);
      rst = 1'b1; rxValid = 1'b1; errClear = 1'b0; tick();
      rst = 1'b0; rxValid = 1'b0;
      chk("rst_intr", {31'd0, hostInterrupt}, 32'd0);
      chk("rst_cnt", {29'd0, fifoCount}, 32'd0);
      chk("rst_err", {29'd0, errStatus}, 32'd0);
      push(8'h55, 1'b0, 1'b0);
      chk("post_rst_lat1", {31'd0, hostInterrupt}, 32'd0);
      tick();
      chk("post_rst_lat2", {31'd0, hostInterrupt}, 32'd1);
      hs(8'h55);
      chk("post_rst_cnt", {29'd0, fifoCount}, 32'd0);

      // Ack already high across reset must not pop the first byte.
      hostAck = 1'b1; rst = 1'b1; tick(); rst = 1'b0;
      push(8'h66, 1'b0, 1'b0);
      repeat (4) tick();
      chk("ackhi_intr", {31'd0, hostInterrupt}, 32'd1);
      chk("ackhi_cnt", {29'd0, fifoCount}, 32'd1);
      hostAck = 1'b0; tick();
      hs(8'h66);
      chk("ackhi_drain", {29'd0, fifoCount}, 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx_host_ctrl.md
UART_RX_HOST_CTRL -- requirements
Module: uart_rx_host_ctrl

Interface
REQ-001 Parameter: FIFO_DEPTH, 4, number of received-byte entries buffered; power of two, 2..16.
REQ-002 Port: overSampler  in  1  16x oversampling clock; sole clock; all logic on its rising edge.
REQ-003 Port: reset  in  1  reset; synchronous and active-high.
REQ-004 Port: rxData  in  8  received data byte from the receiver datapath.
REQ-005 Port: rxValid  in  1  one-cycle pulse; rxData, rxParityErr and rxFrameErr are valid this cycle.
REQ-006 Port: rxParityErr  in  1  even-parity failure flag for the current byte.
REQ-007 Port: rxFrameErr  in  1  stop-bit/framing failure flag for the current byte.
REQ-008 Port: hostData  out  8  byte presented to the host; the FIFO head.
REQ-009 Port: hostInterrupt  out  1  registered; requests host fetch of hostData.
REQ-010 Port: hostAck  in  1  host acknowledge level; held high for one or more cycles.
REQ-011 Port: errStatus  out  3  sticky errors: [2] parity, [1] framing, [0] data overrun.
REQ-012 Port: errClear  in  1  one-cycle pulse; clears errStatus.
REQ-013 Port: fifoCount  out  clog2(FIFO_DEPTH)+1  number of occupied entries.

Function
REQ-014 The FIFO SHALL be circular, with wr_ptr and rd_ptr wrapping modulo FIFO_DEPTH and a separate occupancy counter from 0 to FIFO_DEPTH.
REQ-015 When rxValid=1 and fifoCount<FIFO_DEPTH, the controller SHALL write rxData at wr_ptr and increment the count at that edge.
REQ-016 When rxValid=1 and fifoCount==FIFO_DEPTH with no pop in the same cycle, the controller SHALL drop the byte, leave FIFO contents unchanged, and set errStatus[0].
REQ-017 When a push and a pop occur in the same cycle, both SHALL take effect, the count SHALL be unchanged, and no overrun SHALL be flagged, including when the FIFO is full.
REQ-018 On rxValid=1, errStatus[2] SHALL be set if rxParityErr=1 and errStatus[1] SHALL be set if rxFrameErr=1.
REQ-019 A byte carrying an error flag SHALL still be stored.
REQ-020 When errClear=1, errStatus SHALL clear, except that a bit also being set in the same cycle SHALL end the cycle set (set wins).
REQ-021 hostData SHALL always equal mem[rd_ptr] and is don't-care while fifoCount==0.
REQ-022 hostAck SHALL be registered once (ack_d); the ack rising edge is defined as hostAck=1 and ack_d=0.
REQ-023 The FSM SHALL have four states: IDLE, INTR, POP, WAIT_REL.
REQ-024 IDLE SHALL transition to INTR when fifoCount>0; otherwise it holds.
REQ-025 INTR SHALL transition to POP on an ack rising edge; otherwise it holds.
REQ-026 POP SHALL last one cycle, increment rd_ptr, decrement the count, and transition to WAIT_REL.
REQ-027 WAIT_REL SHALL transition to IDLE when hostAck=0; otherwise it holds.
REQ-028 hostInterrupt SHALL be 1 exactly while the state is INTR.
REQ-029 A rxValid sampled at edge k into an empty FIFO in IDLE SHALL produce hostInterrupt=1 after edge k+1, for a latency of 2 cycles.
REQ-030 After hostAck falls, remaining entries SHALL re-assert hostInterrupt 2 cycles later (WAIT_REL->IDLE->INTR).
REQ-031 An ack rising edge outside INTR SHALL be ignored, and hostAck held high SHALL never cause a second pop.
REQ-032 Exactly one entry SHALL be popped per acknowledge handshake, and the FIFO SHALL never underflow.

Reset
REQ-033 When reset=1 at a clock edge, the state SHALL go to IDLE; wr_ptr, rd_ptr, count and ack_d SHALL go to 0; hostInterrupt SHALL go to 0; errStatus SHALL go to 3'b000; fifoCount SHALL go to 0.
REQ-034 hostData SHALL be don't-care after reset.
REQ-035 Reset SHALL take priority over rxValid, hostAck and errClear in the same cycle.
REQ-036 Reset asserted mid-handshake in any state SHALL discard all buffered bytes.
REQ-037 After reset, the first ack rising edge SHALL require hostAck to have been sampled low at least once.

Verification
REQ-038 Single byte: rxValid with rxData=0xA5 and no errors -> hostInterrupt=1 2 cycles later with hostData=0xA5; an ack pulse gives hostInterrupt=0 and fifoCount=0; errStatus=000.
REQ-039 Burst/overrun (FIFO_DEPTH=4): 5 rxValid pulses 0x01..0x05 with no ack -> fifoCount=4 and errStatus[0]=1; 4 ack handshakes return 0x01..0x04 in order; 0x05 is lost.
REQ-040 Errors: byte 0x3C with rxParityErr=1, then byte 0x7E with rxFrameErr=1 -> errStatus=110 and both bytes delivered; errClear gives 000; errClear coincident with a new rxParityErr gives errStatus[2]=1.
REQ-041 Full + pop collision: FIFO full and in POP while rxValid=1 (0x99) -> fifoCount stays 4, no overrun, and 0x99 is delivered last.
REQ-042 Held ack: hostAck held high for 20 cycles with 2 bytes queued -> exactly 1 pop; the second byte's interrupt appears 2 cycles after hostAck falls.
REQ-043 Reset mid-operation: 3 bytes queued and state INTR, then reset pulse -> hostInterrupt=0, fifoCount=0, errStatus=000; a new byte 0x55 is then delivered normally.
